// File: rtl/writeback_regfile_pkg.sv
// Shared widths and index type for the writeback register file slice.
package writeback_regfile_pkg;
    localparam int XLEN      = 32;
    localparam int PEND_W    = 2;
    localparam int REG_IDX_W = 5;
    localparam int NUM_IDX   = 1 << REG_IDX_W;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/writeback_regfile_if.sv
// Read, issue and writeback channels between decode/execute and the register file.
interface writeback_regfile_if
    import writeback_regfile_pkg::*;
#(
    parameter int XLEN = writeback_regfile_pkg::XLEN
);
    reg_idx_t            rs1_addr;
    reg_idx_t            rs2_addr;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic                hazard_stall;
    logic                issue_valid;
    reg_idx_t            issue_rd;
    logic                issue_ready;
    logic                wb_valid;
    reg_idx_t            wb_rd;
    logic [XLEN-1:0]     wb_data;

    modport master (
        output rs1_addr, rs2_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
        input  rs1_data, rs2_data, hazard_stall, issue_ready
    );

    modport slave (
        input  rs1_addr, rs2_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
        output rs1_data, rs2_data, hazard_stall, issue_ready
    );
endinterface

// File: rtl/writeback_regfile_pend_counter.sv
// Saturating up/down count of in-flight writers for one register; updates on the clock edge.
// inc and dec together hold the count; dec at zero and inc at full are ignored.
module pend_counter
    import writeback_regfile_pkg::*;
#(
    parameter int W = writeback_regfile_pkg::PEND_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         nonzero
);
    assign full    = &count;
    assign nonzero = |count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + 1'b1;
        end else if (dec && !inc && nonzero) begin
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/writeback_regfile.sv
// Register file with same-cycle writeback bypass and per-register pending-writer scoreboard.
// Reads are combinational; issue is refused only when the destination counter is saturated.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int XLEN     = writeback_regfile_pkg::XLEN,
    parameter int NUM_REGS = 32,
    parameter int PEND_W   = writeback_regfile_pkg::PEND_W
) (
    input  logic                clk,
    input  logic                reset_n,
    writeback_regfile_if.slave  rf
);
    logic [XLEN-1:0]    regs_q [NUM_IDX];
    logic [PEND_W-1:0]  cnt    [NUM_IDX];
    logic [NUM_IDX-1:0] full;
    logic [NUM_IDX-1:0] nonzero;
    logic               issue_rdy;

    // A writeback to the same register frees a slot in the cycle it retires.
    assign issue_rdy      = !(full[rf.issue_rd] && !(rf.wb_valid && rf.wb_rd == rf.issue_rd));
    assign rf.issue_ready = issue_rdy;

    for (genvar i = 0; i < NUM_IDX; i++) begin : g_pend
        if (i > 0 && i < NUM_REGS) begin : g_live
            logic inc;
            logic dec;
            assign inc = rf.issue_valid && issue_rdy && rf.issue_rd == reg_idx_t'(i);
            assign dec = rf.wb_valid && rf.wb_rd == reg_idx_t'(i);

            pend_counter #(.W(PEND_W)) u_cnt (
                .clk     (clk),
                .reset_n (reset_n),
                .inc     (inc),
                .dec     (dec),
                .count   (cnt[i]),
                .full    (full[i]),
                .nonzero (nonzero[i])
            );
        end else begin : g_none
            assign cnt[i]     = '0;
            assign full[i]    = 1'b0;
            assign nonzero[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_IDX; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (rf.wb_valid && rf.wb_rd == reg_idx_t'(i)) begin
                    regs_q[i] <= rf.wb_data;
                end
            end
        end
    end

    function automatic logic [XLEN-1:0] read_mux(
        input reg_idx_t        addr,
        input logic            wb_vld,
        input reg_idx_t        wb_rd,
        input logic [XLEN-1:0] wb_dat,
        input logic [XLEN-1:0] stored
    );
        if (addr == '0)                   return '0;
        else if (wb_vld && wb_rd == addr) return wb_dat;
        else                              return stored;
    endfunction

    // A lone outstanding writer retiring this cycle is covered by the bypass.
    function automatic logic hazard(
        input reg_idx_t          addr,
        input logic [PEND_W-1:0] count,
        input logic              nz,
        input logic              wb_vld,
        input reg_idx_t          wb_rd
    );
        return (addr != '0) && nz && !(count == PEND_W'(1) && wb_vld && wb_rd == addr);
    endfunction

    assign rf.rs1_data = read_mux(rf.rs1_addr, rf.wb_valid, rf.wb_rd, rf.wb_data,
                                  regs_q[rf.rs1_addr]);
    assign rf.rs2_data = read_mux(rf.rs2_addr, rf.wb_valid, rf.wb_rd, rf.wb_data,
                                  regs_q[rf.rs2_addr]);

    assign rf.hazard_stall =
        hazard(rf.rs1_addr, cnt[rf.rs1_addr], nonzero[rf.rs1_addr], rf.wb_valid, rf.wb_rd) ||
        hazard(rf.rs2_addr, cnt[rf.rs2_addr], nonzero[rf.rs2_addr], rf.wb_valid, rf.wb_rd);
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed checks of reads, bypass, scoreboard saturation/underflow and async reset.
module tb_writeback_regfile;
    import writeback_regfile_pkg::*;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    writeback_regfile_if #(.XLEN(32)) rf();

    writeback_regfile #(.XLEN(32), .NUM_REGS(32), .PEND_W(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rf      (rf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        rf.rs1_addr    = '0;
        rf.rs2_addr    = '0;
        rf.issue_valid = 1'b0;
        rf.issue_rd    = '0;
        rf.wb_valid    = 1'b0;
        rf.wb_rd       = '0;
        rf.wb_data     = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        idle();
    endtask

    task automatic issue(input reg_idx_t rd);
        rf.issue_valid = 1'b1;
        rf.issue_rd    = rd;
        tick();
    endtask

    task automatic wb(input reg_idx_t rd, input logic [31:0] dat);
        rf.wb_valid = 1'b1;
        rf.wb_rd    = rd;
        rf.wb_data  = dat;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rf.rs1_addr = 5'd5; rf.rs2_addr = 5'd0;
        rf.issue_valid = 1'b1; rf.issue_rd = 5'd7;
        #1;
        checks++; if (rf.rs1_data !== 32'h0) begin errors++; $display("FAIL rst_rs1: got %h want 0", rf.rs1_data); end
        checks++; if (rf.issue_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", rf.issue_ready); end
        checks++; if (rf.hazard_stall !== 1'b0) begin errors++; $display("FAIL rst_hazard: got %b want 0", rf.hazard_stall); end
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        tick();
        rf.rs1_addr = 5'd5; rf.rs2_addr = 5'd0; rf.issue_valid = 1'b1; rf.issue_rd = 5'd5;
        #1;
        checks++; if (rf.rs1_data !== 32'h0) begin errors++; $display("FAIL post_rst_x5: got %h want 0", rf.rs1_data); end
        checks++; if (rf.rs2_data !== 32'h0) begin errors++; $display("FAIL post_rst_x0: got %h want 0", rf.rs2_data); end
        checks++; if (rf.issue_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", rf.issue_ready); end
        checks++; if (rf.hazard_stall !== 1'b0) begin errors++; $display("FAIL post_rst_hazard: got %b want 0", rf.hazard_stall); end
        idle();
    endtask

    task automatic test_bypass();
        rf.wb_valid = 1'b1; rf.wb_rd = 5'd5; rf.wb_data = 32'hDEADBEEF; rf.rs1_addr = 5'd5;
        #1;
        checks++; if (rf.rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_same_cycle: got %h want deadbeef", rf.rs1_data); end
        checks++; if (rf.hazard_stall !== 1'b0) begin errors++; $display("FAIL bypass_hazard: got %b want 0", rf.hazard_stall); end
        tick();
        rf.rs1_addr = 5'd5; rf.rs2_addr = 5'd5;
        #1;
        checks++; if (rf.rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_rs1: got %h want deadbeef", rf.rs1_data); end
        checks++; if (rf.rs2_data !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_rs2: got %h want deadbeef", rf.rs2_data); end
        tick();
    endtask

    task automatic test_x0();
        rf.wb_valid = 1'b1; rf.wb_rd = 5'd0; rf.wb_data = 32'h1234; rf.rs2_addr = 5'd0;
        #1;
        checks++; if (rf.rs2_data !== 32'h0) begin errors++; $display("FAIL x0_bypass: got %h want 0", rf.rs2_data); end
        tick();
        rf.rs2_addr = 5'd0; rf.issue_valid = 1'b1; rf.issue_rd = 5'd0;
        #1;
        checks++; if (rf.rs2_data !== 32'h0) begin errors++; $display("FAIL x0_read: got %h want 0", rf.rs2_data); end
        checks++; if (rf.issue_ready !== 1'b1) begin errors++; $display("FAIL x0_issue_ready: got %b want 1", rf.issue_ready); end
        tick();
        rf.rs1_addr = 5'd0; rf.rs2_addr = 5'd0;
        #1;
        checks++; if (rf.hazard_stall !== 1'b0) begin errors++; $display("FAIL x0_hazard: got %b want 0", rf.hazard_stall); end
        idle();
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 3; k++) begin
            rf.issue_valid = 1'b1; rf.issue_rd = 5'd7;
            #1;
            checks++; if (rf.issue_ready !== 1'b1) begin errors++; $display("FAIL sat_fill%0d: got %b want 1", k, rf.issue_ready); end
            tick();
        end
        rf.issue_valid = 1'b1; rf.issue_rd = 5'd7; rf.rs1_addr = 5'd7;
        #1;
        checks++; if (rf.issue_ready !== 1'b0) begin errors++; $display("FAIL sat_full_ready: got %b want 0", rf.issue_ready); end
        checks++; if (rf.hazard_stall !== 1'b1) begin errors++; $display("FAIL sat_hazard: got %b want 1", rf.hazard_stall); end
        tick();
        rf.issue_valid = 1'b1; rf.issue_rd = 5'd7; rf.rs1_addr = 5'd7;
        rf.wb_valid = 1'b1; rf.wb_rd = 5'd7; rf.wb_data = 32'h0000_0077;
        #1;
        checks++; if (rf.issue_ready !== 1'b1) begin errors++; $display("FAIL sat_wb_ready: got %b want 1", rf.issue_ready); end
        checks++; if (rf.hazard_stall !== 1'b1) begin errors++; $display("FAIL sat_wb_hazard: got %b want 1", rf.hazard_stall); end
        checks++; if (rf.rs1_data !== 32'h77) begin errors++; $display("FAIL sat_wb_data: got %h want 77", rf.rs1_data); end
        tick();
        rf.issue_valid = 1'b1; rf.issue_rd = 5'd7;
        #1;
        checks++; if (rf.issue_ready !== 1'b0) begin errors++; $display("FAIL sat_still3: got %b want 0", rf.issue_ready); end
        idle();
        wb(5'd7, 32'h71);
        wb(5'd7, 32'h72);
        rf.issue_valid = 1'b1; rf.issue_rd = 5'd7; rf.rs1_addr = 5'd7;
        #1;
        checks++; if (rf.issue_ready !== 1'b1) begin errors++; $display("FAIL sat_drain_ready: got %b want 1", rf.issue_ready); end
        checks++; if (rf.hazard_stall !== 1'b1) begin errors++; $display("FAIL sat_drain_hazard1: got %b want 1", rf.hazard_stall); end
        idle();
        wb(5'd7, 32'h73);
        rf.rs1_addr = 5'd7;
        #1;
        checks++; if (rf.hazard_stall !== 1'b0) begin errors++; $display("FAIL sat_drained_hazard: got %b want 0", rf.hazard_stall); end
        checks++; if (rf.rs1_data !== 32'h73) begin errors++; $display("FAIL sat_drained_data: got %h want 73", rf.rs1_data); end
        idle();
    endtask

    task automatic test_hazard();
        issue(5'd9);
        rf.rs1_addr = 5'd9;
        #1;
        checks++; if (rf.hazard_stall !== 1'b1) begin errors++; $display("FAIL haz_rs1: got %b want 1", rf.hazard_stall); end
        rf.wb_valid = 1'b1; rf.wb_rd = 5'd9; rf.wb_data = 32'hCAFE0009;
        #1;
        checks++; if (rf.hazard_stall !== 1'b0) begin errors++; $display("FAIL haz_rs1_wb: got %b want 0", rf.hazard_stall); end
        checks++; if (rf.rs1_data !== 32'hCAFE0009) begin errors++; $display("FAIL haz_rs1_data: got %h want cafe0009", rf.rs1_data); end
        tick();
        issue(5'd10);
        rf.rs2_addr = 5'd10;
        #1;
        checks++; if (rf.hazard_stall !== 1'b1) begin errors++; $display("FAIL haz_rs2: got %b want 1", rf.hazard_stall); end
        idle();
        wb(5'd10, 32'h10);
        // Writeback with an empty counter must not wrap it.
        wb(5'd11, 32'h1111);
        issue(5'd11);
        rf.rs2_addr = 5'd11;
        #1;
        checks++; if (rf.hazard_stall !== 1'b1) begin errors++; $display("FAIL underflow_hazard: got %b want 1", rf.hazard_stall); end
        checks++; if (rf.rs2_data !== 32'h1111) begin errors++; $display("FAIL underflow_data: got %h want 1111", rf.rs2_data); end
        idle();
        wb(5'd11, 32'h2222);
    endtask

    task automatic test_async_reset();
        wb(5'd3, 32'h33);
        issue(5'd3);
        issue(5'd3);
        rf.rs1_addr = 5'd3; rf.rs2_addr = 5'd5;
        #1;
        checks++; if (rf.hazard_stall !== 1'b1) begin errors++; $display("FAIL arst_pre_hazard: got %b want 1", rf.hazard_stall); end
        checks++; if (rf.rs1_data !== 32'h33) begin errors++; $display("FAIL arst_pre_data: got %h want 33", rf.rs1_data); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (rf.hazard_stall !== 1'b0) begin errors++; $display("FAIL arst_hazard: got %b want 0", rf.hazard_stall); end
        checks++; if (rf.rs1_data !== 32'h0) begin errors++; $display("FAIL arst_x3: got %h want 0", rf.rs1_data); end
        checks++; if (rf.rs2_data !== 32'h0) begin errors++; $display("FAIL arst_x5: got %h want 0", rf.rs2_data); end
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        rf.wb_valid = 1'b1; rf.wb_rd = 5'd4; rf.wb_data = 32'hA5A5A5A5;
        tick();
        rf.rs1_addr = 5'd4; rf.rs2_addr = 5'd3;
        #1;
        checks++; if (rf.rs1_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL arst_first_wb: got %h want a5a5a5a5", rf.rs1_data); end
        checks++; if (rf.hazard_stall !== 1'b0) begin errors++; $display("FAIL arst_after_hazard: got %b want 0", rf.hazard_stall); end
        idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_x0();
        test_saturate();
        test_hazard();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
